cache_tag_ctrl: RTL

//  Tag/valid/dirty store plus miss-handling FSM for a set-associative cache; directly upstream of cache_lru.

---
 rtl/cache_tag_ctrl.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_tag_ctrl.sv
// Tag/valid/dirty store and miss-handling FSM for a set-associative cache, upstream of cache_lru.
// Define CACHE_TAG_STATS_EN to add saturating hit/miss counters (stat_hits, stat_misses).
module cache_tag_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int LINE_BYTES   = 16,
    parameter int NUM_SET      = 2,
    parameter int WAYS_PER_SET = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [ADDR_W-1:0]               req_addr,
    input  logic                            req_wr,
    output logic                            rsp_valid,
    output logic                            rsp_hit,
    output logic [$clog2(NUM_SET)-1:0]      rsp_set,
    output logic [$clog2(WAYS_PER_SET)-1:0] rsp_way,
    output logic                            lru_victim_req,
    output logic [$clog2(NUM_SET)-1:0]      lru_victim_set,
    input  logic [$clog2(WAYS_PER_SET)-1:0] lru_victim_way,
    output logic                            lru_update_req,
    output logic [$clog2(NUM_SET)-1:0]      lru_update_set,
    output logic [$clog2(WAYS_PER_SET)-1:0] lru_update_way,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic                            mem_req_wb,
    output logic [ADDR_W-1:0]               mem_req_addr,
    input  logic                            mem_rsp_valid
`ifdef CACHE_TAG_STATS_EN
    ,
    output logic [15:0]                     stat_hits,
    output logic [15:0]                     stat_misses
`endif
);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int SET_W = $clog2(NUM_SET);
    localparam int WAY_W = $clog2(WAYS_PER_SET);
    localparam int TAG_W = ADDR_W - OFF_W - SET_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_VICTIM, S_WB_REQ, S_WB_WAIT, S_FILL_REQ, S_FILL_WAIT
    } state_t;

    state_t                                     state_q, state_d;
    logic [TAG_W+SET_W-1:0]                     line_q, line_d;
    logic                                       wr_q, wr_d;
    logic [WAY_W-1:0]                           way_q, way_d;
    logic                                       req_ready_q, req_ready_d;
    logic                                       rsp_valid_q, rsp_valid_d;
    logic                                       rsp_hit_q, rsp_hit_d;
    logic [SET_W-1:0]                           rsp_set_q, rsp_set_d;
    logic [WAY_W-1:0]                           rsp_way_q, rsp_way_d;
    logic                                       victim_req_q, victim_req_d;
    logic [SET_W-1:0]                           victim_set_q, victim_set_d;
    logic                                       update_req_q, update_req_d;
    logic                                       mem_valid_q, mem_valid_d;
    logic                                       mem_wb_q, mem_wb_d;
    logic [ADDR_W-1:0]                          mem_addr_q, mem_addr_d;
    logic [NUM_SET-1:0][WAYS_PER_SET-1:0]       valid_q, valid_d;
    logic [NUM_SET-1:0][WAYS_PER_SET-1:0]       dirty_q, dirty_d;
    logic [TAG_W-1:0]                           tag_ram [NUM_SET][WAYS_PER_SET];
    logic                                       tag_we;

    logic [TAG_W-1:0] req_tag;
    logic [SET_W-1:0] req_set;
    logic             hit_any, inv_any;
    logic [WAY_W-1:0] hit_way, inv_way;
    logic             unused_offset;

    assign req_tag       = line_q[TAG_W+SET_W-1 -: TAG_W];
    assign req_set       = line_q[SET_W-1:0];
    assign unused_offset = ^req_addr[OFF_W-1:0];

    // Descending scan so the lowest matching (or lowest invalid) way is the one kept.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = WAYS_PER_SET - 1; w >= 0; w--) begin
            if (valid_q[req_set][w] && tag_ram[req_set][w] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_set][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default here first so no path can infer a latch.
        state_d      = state_q;
        line_d       = line_q;
        wr_d         = wr_q;
        way_d        = way_q;
        req_ready_d  = req_ready_q;
        rsp_valid_d  = 1'b0;
        rsp_hit_d    = rsp_hit_q;
        rsp_set_d    = rsp_set_q;
        rsp_way_d    = rsp_way_q;
        victim_req_d = 1'b0;
        victim_set_d = victim_set_q;
        update_req_d = 1'b0;
        mem_valid_d  = mem_valid_q;
        mem_wb_d     = mem_wb_q;
        mem_addr_d   = mem_addr_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        tag_we       = 1'b0;
        case (state_q)
            S_IDLE: if (req_valid && req_ready_q) begin
                line_d      = req_addr[ADDR_W-1:OFF_W];
                wr_d        = req_wr;
                req_ready_d = 1'b0;
                state_d     = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit_any) begin
                    rsp_valid_d  = 1'b1;
                    rsp_hit_d    = 1'b1;
                    rsp_set_d    = req_set;
                    rsp_way_d    = hit_way;
                    update_req_d = 1'b1;
                    if (wr_q) dirty_d[req_set][hit_way] = 1'b1;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end else if (inv_any) begin
                    way_d       = inv_way;
                    mem_valid_d = 1'b1;
                    mem_wb_d    = 1'b0;
                    mem_addr_d  = {req_tag, req_set, {OFF_W{1'b0}}};
                    state_d     = S_FILL_REQ;
                end else begin
                    victim_req_d = 1'b1;
                    victim_set_d = req_set;
                    state_d      = S_VICTIM;
                end
            end
            // cache_lru answers combinationally while victim_req is high.
            S_VICTIM: begin
                way_d       = lru_victim_way;
                mem_valid_d = 1'b1;
                if (dirty_q[req_set][lru_victim_way]) begin
                    mem_wb_d   = 1'b1;
                    mem_addr_d = {tag_ram[req_set][lru_victim_way], req_set, {OFF_W{1'b0}}};
                    state_d    = S_WB_REQ;
                end else begin
                    mem_wb_d   = 1'b0;
                    mem_addr_d = {req_tag, req_set, {OFF_W{1'b0}}};
                    state_d    = S_FILL_REQ;
                end
            end
            S_WB_REQ: if (mem_req_ready) begin
                mem_valid_d = 1'b0;
                state_d     = S_WB_WAIT;
            end
            S_WB_WAIT: if (mem_rsp_valid) begin
                dirty_d[req_set][way_q] = 1'b0;
                mem_valid_d = 1'b1;
                mem_wb_d    = 1'b0;
                mem_addr_d  = {req_tag, req_set, {OFF_W{1'b0}}};
                state_d     = S_FILL_REQ;
            end
            S_FILL_REQ: if (mem_req_ready) begin
                mem_valid_d = 1'b0;
                state_d     = S_FILL_WAIT;
            end
            S_FILL_WAIT: if (mem_rsp_valid) begin
                tag_we                  = 1'b1;
                valid_d[req_set][way_q] = 1'b1;
                dirty_d[req_set][way_q] = wr_q;
                rsp_valid_d             = 1'b1;
                rsp_hit_d               = 1'b0;
                rsp_set_d               = req_set;
                rsp_way_d               = way_q;
                update_req_d            = 1'b1;
                req_ready_d             = 1'b1;
                state_d                 = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            line_q       <= '0;
            wr_q         <= 1'b0;
            way_q        <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_set_q    <= '0;
            rsp_way_q    <= '0;
            victim_req_q <= 1'b0;
            victim_set_q <= '0;
            update_req_q <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_wb_q     <= 1'b0;
            mem_addr_q   <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            wr_q         <= wr_d;
            way_q        <= way_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_set_q    <= rsp_set_d;
            rsp_way_q    <= rsp_way_d;
            victim_req_q <= victim_req_d;
            victim_set_q <= victim_set_d;
            update_req_q <= update_req_d;
            mem_valid_q  <= mem_valid_d;
            mem_wb_q     <= mem_wb_d;
            mem_addr_q   <= mem_addr_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
        end
    end

    // NOTE: tags need no reset; a tag is never read while its valid bit is clear.
    always_ff @(posedge clock) begin
        if (tag_we) tag_ram[req_set][way_q] <= req_tag;
    end

`ifdef CACHE_TAG_STATS_EN
    logic [15:0] stat_hits_q, stat_hits_d, stat_misses_q, stat_misses_d;

    always_comb begin
        stat_hits_d   = stat_hits_q;
        stat_misses_d = stat_misses_q;
        if (rsp_valid_d) begin
            if (rsp_hit_d) begin
                if (stat_hits_q != 16'hFFFF) stat_hits_d = stat_hits_q + 16'd1;
            end else begin
                if (stat_misses_q != 16'hFFFF) stat_misses_d = stat_misses_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`endif

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_hit        = rsp_hit_q;
    assign rsp_set        = rsp_set_q;
    assign rsp_way        = rsp_way_q;
    assign lru_victim_req = victim_req_q;
    assign lru_victim_set = victim_set_q;
    assign lru_update_req = update_req_q;
    assign lru_update_set = rsp_set_q;
    assign lru_update_way = rsp_way_q;
    assign mem_req_valid  = mem_valid_q;
    assign mem_req_wb     = mem_wb_q;
    assign mem_req_addr   = mem_addr_q;

endmodule
